// File: rtl/ssd_scan_monitor_pkg.sv
// Shared definitions for the SSD receive path.
// Holds the seven-segment glyph table (active-low C[6:0], bit 0 = segment a) that the display
// encoder and the scan monitor both use. It also provides the segment bit-index names and a
// helper that maps a single-low anode pattern to its digit index.
package ssd_scan_monitor_pkg;

  // Segment bit positions within C[6:0].
  typedef enum int unsigned {
    SegA = 0,
    SegB = 1,
    SegC = 2,
    SegD = 3,
    SegE = 4,
    SegF = 5,
    SegG = 6
  } seg_idx_e;

  localparam logic [6:0] GLYPH_0   = 7'h40;
  localparam logic [6:0] GLYPH_1   = 7'h79;
  localparam logic [6:0] GLYPH_2   = 7'h24;
  localparam logic [6:0] GLYPH_3   = 7'h30;
  localparam logic [6:0] GLYPH_4   = 7'h19;
  localparam logic [6:0] GLYPH_5   = 7'h12;
  localparam logic [6:0] GLYPH_6   = 7'h02;
  localparam logic [6:0] GLYPH_7   = 7'h78;
  localparam logic [6:0] GLYPH_8   = 7'h00;
  localparam logic [6:0] GLYPH_9   = 7'h10;
  localparam logic [6:0] GLYPH_A   = 7'h08;
  localparam logic [6:0] GLYPH_B   = 7'h03;
  localparam logic [6:0] GLYPH_C   = 7'h46;
  localparam logic [6:0] GLYPH_D   = 7'h21;
  localparam logic [6:0] GLYPH_E   = 7'h06;
  localparam logic [6:0] GLYPH_F   = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit index of the single low anode. Only meaningful when exactly one bit is low.
  function automatic logic [1:0] low_index(input logic [3:0] an);
    logic [1:0] idx;
    case (an)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ssd_seg_decoder.sv
// Combinational seven-segment glyph decoder.
// Ports:
//   seg        - active-low segment pattern, seg[0] = a .. seg[6] = g
//   hex        - recovered hex value (0 for blank or unrecognised patterns)
//   is_blank   - pattern is all segments off
//   is_invalid - pattern is neither a hex glyph nor blank
module ssd_seg_decoder
  import ssd_scan_monitor_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       is_blank,
  output logic       is_invalid
);

  always_comb begin
    hex        = 4'h0;
    is_blank   = 1'b0;
    is_invalid = 1'b0;
    case (seg)
      GLYPH_0:   hex = 4'h0;
      GLYPH_1:   hex = 4'h1;
      GLYPH_2:   hex = 4'h2;
      GLYPH_3:   hex = 4'h3;
      GLYPH_4:   hex = 4'h4;
      GLYPH_5:   hex = 4'h5;
      GLYPH_6:   hex = 4'h6;
      GLYPH_7:   hex = 4'h7;
      GLYPH_8:   hex = 4'h8;
      GLYPH_9:   hex = 4'h9;
      GLYPH_A:   hex = 4'hA;
      GLYPH_B:   hex = 4'hB;
      GLYPH_C:   hex = 4'hC;
      GLYPH_D:   hex = 4'hD;
      GLYPH_E:   hex = 4'hE;
      GLYPH_F:   hex = 4'hF;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_monitor.sv
// Receive-side monitor for a multiplexed four-digit seven-segment display.
// It synchronises the segment bus and anodes, waits for each digit to dwell stably, and decodes
// the digit into a shadow frame. Once all four digits have been seen, it publishes the frame
// atomically.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   C[6:0]            - active-low segment bus (C[0] = a)
//   AN3..AN0          - active-low digit anodes
//   D3..D0            - committed hex value per digit
//   blank[3:0]        - committed blank flag per digit
//   frame_done        - one-cycle pulse on each frame commit
//   scan_err          - sticky: stable anode pattern without exactly one low line
//   pattern_err       - sticky: captured segment pattern not a glyph or blank
//   link_lost         - no capture for TIMEOUT_CYCLES cycles
module ssd_scan_monitor
  import ssd_scan_monitor_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] C,
  input  logic       AN3,
  input  logic       AN2,
  input  logic       AN1,
  input  logic       AN0,
  output logic [3:0] D3,
  output logic [3:0] D2,
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic [3:0] blank,
  output logic       frame_done,
  output logic       scan_err,
  output logic       pattern_err,
  output logic       link_lost
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STABLE_PRE = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  // {AN3..AN0, C}; all-ones is the idle bus.
  logic [10:0] sync1_q, sync2_q, prev_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] shadow_hex_q, shadow_hex_d;
  logic [3:0]      shadow_blank_q, shadow_blank_d;

  logic [3:0][3:0] d_q;
  logic [3:0]      blank_q;
  logic            frame_done_q, scan_err_q, pattern_err_q;

  logic [3:0] an_s;
  logic [6:0] c_s;
  logic       same, evt, one_low, capture, bad_scan, commit;
  logic [1:0] dig_idx;
  logic [3:0] dec_hex;
  logic       dec_blank, dec_invalid;

  assign an_s    = sync2_q[10:7];
  assign c_s     = sync2_q[6:0];
  assign same    = (sync2_q == prev_q);
  // Fires once per dwell: only the STABLE-1 -> STABLE transition, never while saturated.
  assign evt     = same && (stab_q == STABLE_PRE);
  assign one_low = ($countones(~an_s) == 1);
  assign dig_idx = low_index(an_s);
  assign capture  = evt && one_low;
  assign bad_scan = evt && !one_low;
  assign commit   = (mask_q == 4'hF);

  ssd_seg_decoder u_dec (
    .seg        (c_s),
    .hex        (dec_hex),
    .is_blank   (dec_blank),
    .is_invalid (dec_invalid)
  );

  always_comb begin
    stab_d = STABLE_MAX;
    if (!same) begin
      stab_d = SW'(1);
    end else if (stab_q != STABLE_MAX) begin
      stab_d = stab_q + SW'(1);
    end
  end

  always_comb begin
    tmo_d = TIMEOUT_MAX;
    if (capture) begin
      tmo_d = '0;
    end else if (tmo_q != TIMEOUT_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // The commit reads the old shadow contents, so a capture in the commit cycle starts the next
  // frame.
  always_comb begin
    mask_d         = commit ? 4'h0 : mask_q;
    shadow_hex_d   = shadow_hex_q;
    shadow_blank_d = shadow_blank_q;
    if (capture) begin
      mask_d[dig_idx]         = 1'b1;
      shadow_hex_d[dig_idx]   = dec_hex;
      shadow_blank_d[dig_idx] = dec_blank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      prev_q         <= '1;
      stab_q         <= '0;
      tmo_q          <= '0;
      mask_q         <= '0;
      shadow_hex_q   <= '0;
      shadow_blank_q <= '0;
      d_q            <= '0;
      blank_q        <= 4'hF;
      frame_done_q   <= 1'b0;
      scan_err_q     <= 1'b0;
      pattern_err_q  <= 1'b0;
    end else begin
      sync1_q        <= {AN3, AN2, AN1, AN0, C};
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      stab_q         <= stab_d;
      tmo_q          <= tmo_d;
      mask_q         <= mask_d;
      shadow_hex_q   <= shadow_hex_d;
      shadow_blank_q <= shadow_blank_d;
      frame_done_q   <= commit;
      if (commit) begin
        d_q     <= shadow_hex_q;
        blank_q <= shadow_blank_q;
      end
      if (bad_scan) begin
        scan_err_q <= 1'b1;
      end
      if (capture && dec_invalid) begin
        pattern_err_q <= 1'b1;
      end
    end
  end

  assign D0          = d_q[0];
  assign D1          = d_q[1];
  assign D2          = d_q[2];
  assign D3          = d_q[3];
  assign blank       = blank_q;
  assign frame_done  = frame_done_q;
  assign scan_err    = scan_err_q;
  assign pattern_err = pattern_err_q;
  assign link_lost   = (tmo_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_ssd_scan_monitor.sv
// Scoreboard bench for ssd_scan_monitor. Stimulus is a sequence of (anode, segment, dwell)
// segments. A reference model works at the dwell level: a run of identical input lasting at
// least STABLE_CYCLES produces one event. The model uses that to predict frames, sticky flags
// and capture times. A negedge monitor pops expected frames on frame_done and checks link_lost
// every cycle.
module tb_ssd_scan_monitor;

  localparam int unsigned S     = 4;
  localparam int unsigned TO    = 50;
  localparam int unsigned DRAIN = S + 3;

  typedef struct packed {
    logic [3:0][3:0] d;
    logic [3:0]      b;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] c_drv = 7'h7F;
  logic [3:0] an_drv = 4'hF;
  logic [3:0] d3, d2, d1, d0, blank;
  logic       frame_done, scan_err, pattern_err, link_lost;

  always #5 clk = ~clk;

  ssd_scan_monitor #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .C           (c_drv),
    .AN3         (an_drv[3]),
    .AN2         (an_drv[2]),
    .AN1         (an_drv[1]),
    .AN0         (an_drv[0]),
    .D3          (d3),
    .D2          (d2),
    .D1          (d1),
    .D0          (d0),
    .blank       (blank),
    .frame_done  (frame_done),
    .scan_err    (scan_err),
    .pattern_err (pattern_err),
    .link_lost   (link_lost)
  );

  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned edge_cnt = 0;
  int unsigned last_cap = 0;
  int unsigned cap_q [$];
  frame_t      exp_q [$];
  bit          running = 1'b0;

  // Reference model state.
  logic [3:0]      mask_m;
  logic [3:0][3:0] slot_v, exp_d;
  logic [3:0]      slot_b, exp_b;
  logic            exp_serr, exp_perr;
  logic [11:0]     run_val;
  int unsigned     run_len, run_start;
  bit              run_fired;
  logic [3:0]      cur_an;
  logic [6:0]      cur_c;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] a;
    a = 4'b0001 << k;
    return ~a;
  endfunction

  task automatic ref_decode(input logic [6:0] c, output logic [3:0] v, output logic b,
                            output logic bad);
    v   = 4'h0;
    b   = 1'b0;
    bad = 1'b1;
    if (c == 7'h7F) begin
      b   = 1'b1;
      bad = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (glyphs[i] == c) begin
          v   = 4'(i);
          bad = 1'b0;
        end
      end
    end
  endtask

  task automatic model_event(input logic [3:0] an, input logic [6:0] c, input int unsigned ce);
    int       lows;
    int       k;
    logic [3:0] v;
    logic     b, bad;
    frame_t   fr;
    lows = 0;
    k    = 0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) begin
        lows++;
        k = i;
      end
    end
    if (lows != 1) begin
      exp_serr = 1'b1;
      return;
    end
    ref_decode(c, v, b, bad);
    slot_v[k] = v;
    slot_b[k] = b;
    if (bad) exp_perr = 1'b1;
    mask_m[k] = 1'b1;
    cap_q.push_back(ce);
    if (mask_m == 4'hF) begin
      exp_d  = slot_v;
      exp_b  = slot_b;
      fr.d   = slot_v;
      fr.b   = slot_b;
      exp_q.push_back(fr);
      mask_m = 4'h0;
    end
  endtask

  // Called #1 after a posedge; the next edge is the first to sample the new value.
  task automatic drive_seg(input logic [3:0] an, input logic [6:0] c, input int unsigned d);
    logic [11:0] v;
    v = {1'b0, an, c};
    if (v == run_val) begin
      run_len += d;
    end else begin
      run_val   = v;
      run_len   = d;
      run_start = edge_cnt + 1;
      run_fired = 1'b0;
    end
    if (!run_fired && run_len >= S) begin
      run_fired = 1'b1;
      model_event(an, c, run_start + S + 1);
    end
    cur_an = an;
    cur_c  = c;
    an_drv = an;
    c_drv  = c;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic check_phase(input string name);
    drive_seg(cur_an, cur_c, DRAIN);
    chk({name, "_D"}, {d3, d2, d1, d0}, exp_d);
    chk({name, "_blank"}, blank, exp_b);
    chk({name, "_scan_err"}, scan_err, exp_serr);
    chk({name, "_pattern_err"}, pattern_err, exp_perr);
  endtask

  task automatic do_reset();
    chk("frames_pending_before_reset", exp_q.size(), 0);
    running = 1'b0;
    rst     = 1'b1;
    cap_q.delete();
    exp_q.delete();
    mask_m   = 4'h0;
    slot_v   = '0;
    slot_b   = '0;
    exp_d    = '0;
    exp_b    = 4'hF;
    exp_serr = 1'b0;
    exp_perr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_D", {d3, d2, d1, d0}, 16'h0);
    chk("rst_blank", blank, 4'hF);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_scan_err", scan_err, 1'b0);
    chk("rst_pattern_err", pattern_err, 1'b0);
    chk("rst_link_lost", link_lost, 1'b0);
    rst       = 1'b0;
    last_cap  = edge_cnt;
    run_val   = 12'h800;
    run_fired = 1'b1;
    running   = 1'b1;
  endtask

  task automatic scan_frame(input int g0, input int g1, input int g2, input int g3,
                            input int unsigned d);
    drive_seg(an_of(0), glyphs[g0], d);
    drive_seg(an_of(1), glyphs[g1], d);
    drive_seg(an_of(2), glyphs[g2], d);
    drive_seg(an_of(3), glyphs[g3], d);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    frame_t f;
    if (running && !rst) begin
      while (cap_q.size() != 0 && cap_q[0] <= edge_cnt) last_cap = cap_q.pop_front();
      chk("link_lost", link_lost, (edge_cnt - last_cap) >= TO);
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          chk("frame_done_unexpected", frame_done, 1'b0);
        end else begin
          f = exp_q.pop_front();
          chk("frame_D", {d3, d2, d1, d0}, f.d);
          chk("frame_blank", blank, f.b);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [3:0]  an;
    logic [6:0]  c;
    int unsigned r;
    do_reset();

    // Basic scan 0,1,2,3.
    scan_frame(0, 1, 2, 3, 8);
    check_phase("basic");

    // Dwell just long enough commits; dwell one short never captures.
    scan_frame(5, 6, 7, 8, S + 1);
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 4; k++) drive_seg(an_of(k), glyphs[9 + k], S - 1);
    end
    scan_frame(1, 2, 3, 4, 8);
    check_phase("dwell");

    // Blank on digit 2 and a bad pattern on digit 3; the error stays set through a clean frame.
    drive_seg(an_of(0), glyphs[5], 8);
    drive_seg(an_of(1), glyphs[6], 8);
    drive_seg(an_of(2), 7'h7F, 8);
    drive_seg(an_of(3), 7'h55, 8);
    check_phase("pattern");
    scan_frame(10, 11, 12, 13, 8);
    check_phase("pattern_sticky");

    // Two anodes low in the middle of a scan.
    drive_seg(an_of(0), glyphs[14], 8);
    drive_seg(an_of(1), glyphs[15], 8);
    drive_seg(4'b1100, glyphs[0], 8);
    drive_seg(4'b1011, glyphs[1], 8);
    drive_seg(an_of(3), glyphs[2], 8);
    check_phase("scan");

    // Scanning stops: link_lost rises and outputs hold; a capture clears it.
    scan_frame(9, 8, 7, 6, 8);
    drive_seg(4'hF, 7'h7F, 60);
    check_phase("timeout");
    scan_frame(3, 5, 7, 9, 8);
    check_phase("relink");

    // Reset with three of four digits captured.
    drive_seg(an_of(0), glyphs[1], 8);
    drive_seg(an_of(1), glyphs[1], 8);
    drive_seg(an_of(2), glyphs[1], 8);
    do_reset();
    scan_frame(4, 3, 2, 1, 8);
    check_phase("after_reset");

    // Random scanning with occasional bad anodes, blanks and junk patterns.
    for (int i = 0; i < 240; i++) begin
      an = an_of($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) an = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      if (r < 16) c = glyphs[r];
      else if (r < 18) c = 7'h7F;
      else c = 7'($urandom_range(0, 127));
      drive_seg(an, c, $urandom_range(S - 2, S + 6));
    end
    check_phase("random");

    chk("frames_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
